nn_access_arbiter: RTL and testbench

Shares the single mlp_OX classifier between two requesters: the training sample stream from train_controller and user-submitted inference inputs from input_manager. Grants one sample at a time, drives and holds the NN input/label/learn lines for a fixed evaluation window, and returns a per-request completion pulse. On inference grants it also captures the classifier result. It replaces the static training_active mux in top, so a submit during training is serviced between training samples instead of being ignored.

---
 rtl/nn_access_arbiter.sv | 156 +++++++++++++++
 tb/tb_nn_access_arbiter.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/nn_access_arbiter.sv
// nn_access_arbiter: shares the single mlp_OX classifier between the training
// sample stream and user inference requests. One sample is granted at a time.
// The NN input is held for NN_LAT cycles, then a one-cycle completion pulse is
// returned to the owner. Inference grants also capture the classifier result.
module nn_access_arbiter #(
    parameter int XW             = 16,
    parameter int PW             = 7,
    parameter int NN_LAT         = 4,
    parameter int MAX_INF_STREAK = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          train_req,
    input  logic [XW-1:0] train_x,
    input  logic          train_is_O,
    input  logic          inf_req,
    input  logic [XW-1:0] inf_x,
    input  logic          nn_y,
    input  logic [PW-1:0] nn_prob_pct,
    output logic [XW-1:0] nn_x,
    output logic          nn_learn,
    output logic          nn_is_O,
    output logic          busy,
    output logic          owner,
    output logic          train_ack,
    output logic          inf_done,
    output logic          inf_y,
    output logic [PW-1:0] inf_prob_pct
);

    localparam int CW = (NN_LAT > 1) ? $clog2(NN_LAT) : 1;
    localparam int SW = (MAX_INF_STREAK > 0) ? $clog2(MAX_INF_STREAK + 1) : 1;

    localparam logic OWN_TRAIN = 1'b0;
    localparam logic OWN_INF   = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state, state_d;
    logic [CW-1:0] cnt, cnt_d;
    logic [SW-1:0] streak, streak_d;
    logic [XW-1:0] nn_x_d;
    logic          nn_learn_d, nn_is_O_d, busy_d, owner_d;
    logic          train_ack_d, inf_done_d, inf_y_d;
    logic [PW-1:0] inf_prob_pct_d;
    logic          inf_wins;

    // Inference has priority unless it has already starved a waiting
    // training request for MAX_INF_STREAK consecutive grants.
    assign inf_wins = inf_req && !(train_req && (streak == SW'(MAX_INF_STREAK)));

    // Next-state and next-output logic; every output is registered below.
    always_comb begin
        // NOTE: every signal gets a default first so no path can infer a latch.
        state_d        = state;
        cnt_d          = cnt;
        streak_d       = streak;
        nn_x_d         = nn_x;
        nn_learn_d     = 1'b0;
        nn_is_O_d      = nn_is_O;
        busy_d         = busy;
        owner_d        = owner;
        train_ack_d    = 1'b0;
        inf_done_d     = 1'b0;
        inf_y_d        = inf_y;
        inf_prob_pct_d = inf_prob_pct;

        case (state)
            IDLE: begin
                nn_x_d    = '0;
                nn_is_O_d = 1'b0;
                busy_d    = 1'b0;
                if (inf_req || train_req) begin
                    state_d = BUSY;
                    busy_d  = 1'b1;
                    cnt_d   = CW'(NN_LAT - 1);
                    if (inf_wins) begin
                        owner_d = OWN_INF;
                        nn_x_d  = inf_x;
                        if (train_req && (streak != SW'(MAX_INF_STREAK)))
                            streak_d = streak + SW'(1);
                    end else begin
                        owner_d    = OWN_TRAIN;
                        nn_x_d     = train_x;
                        nn_is_O_d  = train_is_O;
                        streak_d   = '0;
                        // With a one-cycle window the first BUSY cycle is the learn cycle.
                        nn_learn_d = (NN_LAT == 1);
                    end
                end
            end
            BUSY: begin
                if (cnt == '0) begin
                    state_d     = DONE;
                    nn_x_d      = '0;
                    nn_is_O_d   = 1'b0;
                    train_ack_d = (owner == OWN_TRAIN);
                    inf_done_d  = (owner == OWN_INF);
                    if (owner == OWN_INF) begin
                        inf_y_d        = nn_y;
                        inf_prob_pct_d = nn_prob_pct;
                    end
                end else begin
                    cnt_d = cnt - CW'(1);
                    // Learn is registered, so raise it entering the cnt==0 cycle.
                    nn_learn_d = (cnt == CW'(1)) && (owner == OWN_TRAIN);
                end
            end
            DONE: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers, all cleared by the asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            cnt          <= '0;
            streak       <= '0;
            nn_x         <= '0;
            nn_learn     <= 1'b0;
            nn_is_O      <= 1'b0;
            busy         <= 1'b0;
            owner        <= 1'b0;
            train_ack    <= 1'b0;
            inf_done     <= 1'b0;
            inf_y        <= 1'b0;
            inf_prob_pct <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all
            // registers update together from pre-edge values.
            state        <= state_d;
            cnt          <= cnt_d;
            streak       <= streak_d;
            nn_x         <= nn_x_d;
            nn_learn     <= nn_learn_d;
            nn_is_O      <= nn_is_O_d;
            busy         <= busy_d;
            owner        <= owner_d;
            train_ack    <= train_ack_d;
            inf_done     <= inf_done_d;
            inf_y        <= inf_y_d;
            inf_prob_pct <= inf_prob_pct_d;
        end
    end

endmodule

// File: tb/tb_nn_access_arbiter.sv
// Directed bench for nn_access_arbiter: one instance with NN_LAT=4 and one
// with NN_LAT=1, sharing clock and reset. Inputs change 1 time unit after the
// rising edge; outputs are checked at that same point, i.e. for the cycle
// that just started.
module tb_nn_access_arbiter;

    localparam int XW = 16;
    localparam int PW = 7;

    logic clk = 1'b0;
    logic rst = 1'b1;

    // NN_LAT=4 instance
    logic          train_req, train_is_O, inf_req, nn_y;
    logic [XW-1:0] train_x, inf_x;
    logic [PW-1:0] nn_prob_pct;
    logic [XW-1:0] nn_x;
    logic          nn_learn, nn_is_O, busy, owner, train_ack, inf_done, inf_y;
    logic [PW-1:0] inf_prob_pct;

    // NN_LAT=1 instance
    logic          train_req1, train_is_O1, inf_req1, nn_y1;
    logic [XW-1:0] train_x1, inf_x1;
    logic [PW-1:0] nn_prob_pct1;
    logic [XW-1:0] nn_x1;
    logic          nn_learn1, nn_is_O1, busy1, owner1, train_ack1, inf_done1, inf_y1;
    logic [PW-1:0] inf_prob_pct1;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    nn_access_arbiter #(.XW(XW), .PW(PW), .NN_LAT(4), .MAX_INF_STREAK(3)) dut (
        .clk(clk), .rst(rst),
        .train_req(train_req), .train_x(train_x), .train_is_O(train_is_O),
        .inf_req(inf_req), .inf_x(inf_x),
        .nn_y(nn_y), .nn_prob_pct(nn_prob_pct),
        .nn_x(nn_x), .nn_learn(nn_learn), .nn_is_O(nn_is_O),
        .busy(busy), .owner(owner), .train_ack(train_ack), .inf_done(inf_done),
        .inf_y(inf_y), .inf_prob_pct(inf_prob_pct)
    );

    nn_access_arbiter #(.XW(XW), .PW(PW), .NN_LAT(1), .MAX_INF_STREAK(3)) dut1 (
        .clk(clk), .rst(rst),
        .train_req(train_req1), .train_x(train_x1), .train_is_O(train_is_O1),
        .inf_req(inf_req1), .inf_x(inf_x1),
        .nn_y(nn_y1), .nn_prob_pct(nn_prob_pct1),
        .nn_x(nn_x1), .nn_learn(nn_learn1), .nn_is_O(nn_is_O1),
        .busy(busy1), .owner(owner1), .train_ack(train_ack1), .inf_done(inf_done1),
        .inf_y(inf_y1), .inf_prob_pct(inf_prob_pct1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        train_req = 0; train_x = '0; train_is_O = 0; inf_req = 0; inf_x = '0;
        nn_y = 0; nn_prob_pct = '0;
        train_req1 = 0; train_x1 = '0; train_is_O1 = 0; inf_req1 = 0; inf_x1 = '0;
        nn_y1 = 0; nn_prob_pct1 = '0;

        // Reset state, checked before any clock edge.
        #3;
        check("rst_nn_x", 32'(nn_x), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_owner", 32'(owner), 0);
        check("rst_inf_prob", 32'(inf_prob_pct), 0);
        check("rst_learn1", 32'(nn_learn1), 0);
        step(); step();
        rst = 0;
        step();

        // 1: inference grant, result capture.
        inf_req = 1; inf_x = 16'h0F0F; nn_y = 1; nn_prob_pct = 7'd87;
        for (int i = 1; i <= 4; i++) begin
            step();
            check("inf_nn_x", 32'(nn_x), 32'h0F0F);
            check("inf_busy", 32'(busy), 1);
            check("inf_learn", 32'(nn_learn), 0);
            check("inf_done_early", 32'(inf_done), 0);
        end
        check("inf_owner", 32'(owner), 1);
        step();
        check("inf_done", 32'(inf_done), 1);
        check("inf_y", 32'(inf_y), 1);
        check("inf_prob", 32'(inf_prob_pct), 87);
        check("inf_done_nn_x", 32'(nn_x), 0);
        check("inf_done_busy", 32'(busy), 1);
        inf_req = 0;
        step();
        check("inf_idle_busy", 32'(busy), 0);
        check("inf_done_pulse", 32'(inf_done), 0);

        // 2: training grant, one learn strobe, inference result untouched.
        train_req = 1; train_x = 16'h9009; train_is_O = 1; nn_y = 0; nn_prob_pct = 7'd12;
        for (int i = 1; i <= 4; i++) begin
            step();
            check("trn_nn_x", 32'(nn_x), 32'h9009);
            check("trn_is_O", 32'(nn_is_O), 1);
            check("trn_learn", 32'(nn_learn), (i == 4) ? 1 : 0);
            check("trn_owner", 32'(owner), 0);
        end
        step();
        check("trn_ack", 32'(train_ack), 1);
        check("trn_inf_done", 32'(inf_done), 0);
        check("trn_inf_y", 32'(inf_y), 1);
        check("trn_inf_prob", 32'(inf_prob_pct), 87);
        check("trn_learn_off", 32'(nn_learn), 0);
        train_req = 0;
        step();
        check("trn_idle_owner", 32'(owner), 0);

        // 3: both held; order I,I,I,T,I,I,I,T, grants every 6 cycles.
        train_req = 1; train_x = 16'h5555; train_is_O = 0;
        inf_req = 1; inf_x = 16'hAAAA;
        for (int c = 1; c <= 47; c++) begin
            step();
            if (c % 6 == 1) begin
                check("arb_owner", 32'(owner), ((c / 6) % 4 != 3) ? 1 : 0);
                check("arb_nn_x", 32'(nn_x), ((c / 6) % 4 != 3) ? 32'hAAAA : 32'h5555);
            end
            if (c % 6 == 0) check("arb_gap", 32'(busy), 0);
        end
        check("arb_last_ack", 32'(train_ack), 1);
        train_req = 0; inf_req = 0;
        step();

        // 4: inference request dropped mid-grant still completes.
        inf_req = 1; inf_x = 16'h1234; nn_y = 0; nn_prob_pct = 7'd42;
        step(); step();
        inf_req = 0;
        step(); step();
        check("drop_busy", 32'(busy), 1);
        check("drop_nn_x", 32'(nn_x), 32'h1234);
        step();
        check("drop_done", 32'(inf_done), 1);
        check("drop_inf_y", 32'(inf_y), 0);
        check("drop_prob", 32'(inf_prob_pct), 42);
        step(); step();
        check("drop_no_regrant", 32'(busy), 0);

        // 5: asynchronous reset during a training grant.
        train_req = 1; train_x = 16'h00FF; train_is_O = 0;
        step(); step();
        check("rstm_busy_pre", 32'(busy), 1);
        #1 rst = 1;
        #1;
        check("rstm_nn_x", 32'(nn_x), 0);
        check("rstm_busy", 32'(busy), 0);
        check("rstm_prob", 32'(inf_prob_pct), 0);
        step();
        check("rstm_ack", 32'(train_ack), 0);
        rst = 0;
        step();
        check("rstm_regrant_busy", 32'(busy), 1);
        check("rstm_regrant_nn_x", 32'(nn_x), 32'h00FF);
        step(); step(); step();
        check("rstm_learn", 32'(nn_learn), 1);
        step();
        check("rstm_ack_after", 32'(train_ack), 1);
        train_req = 0;
        step();

        // 6: NN_LAT=1 corner, result taken from first-BUSY-cycle values.
        inf_req1 = 1; inf_x1 = 16'hC3C3; nn_y1 = 0; nn_prob_pct1 = 7'd10;
        step();
        check("lat1_busy", 32'(busy1), 1);
        check("lat1_nn_x", 32'(nn_x1), 32'hC3C3);
        check("lat1_learn", 32'(nn_learn1), 0);
        nn_y1 = 1; nn_prob_pct1 = 7'd55;
        step();
        check("lat1_done", 32'(inf_done1), 1);
        check("lat1_inf_y", 32'(inf_y1), 1);
        check("lat1_prob", 32'(inf_prob_pct1), 55);
        check("lat1_nn_x_clr", 32'(nn_x1), 0);
        inf_req1 = 0; nn_y1 = 0; nn_prob_pct1 = 7'd99;
        step();
        check("lat1_idle", 32'(busy1), 0);
        train_req1 = 1; train_x1 = 16'h8001; train_is_O1 = 1;
        step();
        check("lat1_trn_learn", 32'(nn_learn1), 1);
        check("lat1_trn_is_O", 32'(nn_is_O1), 1);
        step();
        check("lat1_trn_ack", 32'(train_ack1), 1);
        check("lat1_trn_learn_off", 32'(nn_learn1), 0);
        check("lat1_trn_prob_held", 32'(inf_prob_pct1), 55);
        train_req1 = 0;
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
